// File: rtl/axi4s_packet_fifo_if.sv
// AXI4-Stream beat bundle for axi4s_packet_fifo.
// master drives the beat, slave returns tready.
interface axi4s_packet_fifo_if #(
  parameter int DATA_BYTES = 8
);
  logic [8*DATA_BYTES-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/axi4s_packet_fifo.sv
// AXI4-Stream FIFO, store-and-forward or cut-through, packet counter.
// AXI4S_PKT_FIFO_DROP_EN: drop packets on overflow instead of backpressure.
module axi4s_packet_fifo #(
  parameter int DATA_BYTES  = 8,
  parameter int DEPTH       = 64,
  parameter int PACKET_MODE = 1,
  parameter int PKT_CNT_W   = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  axi4s_packet_fifo_if.slave     s_axis,
  axi4s_packet_fifo_if.master    m_axis,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [PKT_CNT_W-1:0]   pkt_count,
  output logic [PKT_CNT_W-1:0]   drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = 8 * DATA_BYTES;
  localparam int EW = DW + DATA_BYTES + 1;

  logic [EW-1:0]          r_mem [DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_commit_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic                   r_ovs;
  logic [DW-1:0]          r_m_data;
  logic [DATA_BYTES-1:0]  r_m_keep;
  logic                   r_m_last;
  logic                   r_m_valid;
  logic [PKT_CNT_W-1:0]   r_pkt_cnt;

  logic [PW-1:0] w_used;
  logic [PW-1:0] w_rd_limit;
  logic [PW-1:0] w_rewind;
  logic          w_rewind_en;
  logic          w_full;
  logic          w_no_commit;
  logic          w_ovs;
  logic          w_wr;
  logic          w_rd_avail;
  logic          w_pop;
  logic          w_load;
  logic          w_inc;
  logic          w_dec;

  assign w_used      = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_used == PW'(DEPTH));
  assign w_no_commit = (r_commit_ptr == r_rd_ptr);

`ifdef AXI4S_PKT_FIFO_DROP_EN
  logic                 r_drop;
  logic [PKT_CNT_W-1:0] r_drop_cnt;
  logic [PW-1:0]        w_rc;
  logic [PW-1:0]        w_wc;
  logic                 w_accept;
  logic                 w_discard;
  logic                 w_drop_end;

  assign s_axis.tready = !areset;
  assign w_accept      = s_axis.tvalid & !areset;
  assign w_discard     = w_accept & (r_drop | w_full);
  assign w_wr          = w_accept & !w_discard;
  assign w_drop_end    = w_discard & s_axis.tlast;
  assign w_rewind_en   = w_discard & !r_drop;
  // Beats already read past commit cannot be recalled:
  // rewind no further back than the read pointer.
  assign w_rc          = r_rd_ptr - r_commit_ptr;
  assign w_wc          = r_wr_ptr - r_commit_ptr;
  assign w_rewind      = (w_rc != '0 && w_rc <= w_wc) ?
                         r_rd_ptr : r_commit_ptr;
  assign drop_count    = r_drop_cnt;

  // Discard state spans the overflowing packet up to its tlast.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_drop     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_drop_end)
        r_drop <= 1'b0;
      else if (w_discard)
        r_drop <= 1'b1;
      if (w_drop_end && r_drop_cnt != '1)
        r_drop_cnt <= r_drop_cnt + PKT_CNT_W'(1);
    end
  end
`else
  assign s_axis.tready = !areset & !w_full;
  assign w_wr          = s_axis.tvalid & s_axis.tready;
  assign w_rewind_en   = 1'b0;
  assign w_rewind      = '0;
  assign drop_count    = '0;
`endif

  // Oversize packet: full with nothing committed reads uncommitted data.
  assign w_ovs      = r_ovs | (w_full & w_no_commit);
  assign w_rd_limit = w_rewind_en ? w_rewind :
                      (PACKET_MODE != 0 && !w_ovs) ?
                      r_commit_ptr : r_wr_ptr;
  assign w_rd_avail = (r_rd_ptr != w_rd_limit);
  assign w_pop      = r_m_valid & m_axis.tready;
  assign w_load     = w_rd_avail & (!r_m_valid | m_axis.tready);
  assign w_inc      = w_wr & s_axis.tlast;
  assign w_dec      = w_pop & r_m_last;

  // Storage array, no reset needed: pointers qualify every entry.
  always_ff @(posedge aclk) begin
    if (w_wr)
      r_mem[r_wr_ptr[AW-1:0]] <=
        {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
  end

  // Write, commit and read pointers plus oversize flag.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_ovs        <= 1'b0;
    end else begin
      if (w_rewind_en) begin
        r_wr_ptr     <= w_rewind;
        r_commit_ptr <= w_rewind;
        r_ovs        <= 1'b0;
      end else begin
        if (w_wr)
          r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_inc) begin
          r_commit_ptr <= r_wr_ptr + PW'(1);
          r_ovs        <= 1'b0;
        end else if (w_full && w_no_commit) begin
          r_ovs <= 1'b1;
        end
      end
      if (w_load)
        r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // One-entry output register, refilled on the popping edge.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
      r_m_valid <= 1'b0;
    end else if (w_load) begin
      {r_m_last, r_m_keep, r_m_data} <= r_mem[r_rd_ptr[AW-1:0]];
      r_m_valid <= 1'b1;
    end else if (w_pop) begin
      r_m_valid <= 1'b0;
    end
  end

  // Complete packets held, saturating in both directions.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_pkt_cnt <= '0;
    end else begin
      unique case ({w_inc, w_dec})
        2'b10: if (r_pkt_cnt != '1)
                 r_pkt_cnt <= r_pkt_cnt + PKT_CNT_W'(1);
        2'b01: if (r_pkt_cnt != '0)
                 r_pkt_cnt <= r_pkt_cnt - PKT_CNT_W'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  assign m_axis.tdata  = r_m_data;
  assign m_axis.tkeep  = r_m_keep;
  assign m_axis.tlast  = r_m_last;
  assign m_axis.tvalid = r_m_valid;
  assign fill_level    = w_used;
  assign pkt_count     = r_pkt_cnt;
endmodule

// File: tb/tb_axi4s_packet_fifo.sv
// Bench for axi4s_packet_fifo: packet-mode and cut-through instances.
// Table vectors, directed corner sequences, random scoreboard.
module tb_axi4s_packet_fifo;
  logic clk;
  logic areset;
  logic [4:0] p_fill, c_fill;
  logic [7:0] p_pkt, p_drop, c_pkt, c_drop;
  int n_cmp = 0;
  int n_err = 0;

`ifdef AXI4S_PKT_FIFO_DROP_EN
  localparam int MAXL = 16;
`else
  localparam int MAXL = 20;
`endif
  localparam int NP = 60;

  axi4s_packet_fifo_if #(.DATA_BYTES(8)) ps ();
  axi4s_packet_fifo_if #(.DATA_BYTES(8)) pm ();
  axi4s_packet_fifo_if #(.DATA_BYTES(8)) cs ();
  axi4s_packet_fifo_if #(.DATA_BYTES(8)) cm ();

  axi4s_packet_fifo #(
    .DATA_BYTES(8), .DEPTH(16), .PACKET_MODE(1), .PKT_CNT_W(8)
  ) u_pkt (
    .aclk(clk), .areset(areset),
    .s_axis(ps), .m_axis(pm),
    .fill_level(p_fill), .pkt_count(p_pkt), .drop_count(p_drop)
  );

  axi4s_packet_fifo #(
    .DATA_BYTES(8), .DEPTH(16), .PACKET_MODE(0), .PKT_CNT_W(8)
  ) u_ct (
    .aclk(clk), .areset(areset),
    .s_axis(cs), .m_axis(cm),
    .fill_level(c_fill), .pkt_count(c_pkt), .drop_count(c_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          ct;
    bit          sv;
    logic [63:0] sd;
    logic [7:0]  sk;
    bit          sl;
    bit          mr;
    bit          ev;
    logic [63:0] ed;
    logic [7:0]  ek;
    bit          el;
    int          ef;
    int          ep;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    bit ct, bit sv, logic [63:0] sd, logic [7:0] sk, bit sl,
    bit mr, bit ev, logic [63:0] ed, logic [7:0] ek, bit el,
    int ef, int ep, string nm);
    vec_t v;
    v.ct = ct; v.sv = sv; v.sd = sd; v.sk = sk; v.sl = sl;
    v.mr = mr; v.ev = ev; v.ed = ed; v.ek = ek; v.el = el;
    v.ef = ef; v.ep = ep; v.nm = nm;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [79:0] act,
                     input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    logic        mv, ml;
    logic [63:0] md;
    logic [7:0]  mk_;
    int          f, pk;
    if (v.ct) begin
      cs.tvalid = v.sv; cs.tdata = v.sd; cs.tkeep = v.sk;
      cs.tlast = v.sl; cm.tready = v.mr; ps.tvalid = 1'b0;
    end else begin
      ps.tvalid = v.sv; ps.tdata = v.sd; ps.tkeep = v.sk;
      ps.tlast = v.sl; pm.tready = v.mr; cs.tvalid = 1'b0;
    end
    @(posedge clk); #1;
    if (v.ct) begin
      mv = cm.tvalid; md = cm.tdata; mk_ = cm.tkeep; ml = cm.tlast;
      f = int'(c_fill); pk = int'(c_pkt);
    end else begin
      mv = pm.tvalid; md = pm.tdata; mk_ = pm.tkeep; ml = pm.tlast;
      f = int'(p_fill); pk = int'(p_pkt);
    end
    chk({v.nm, ".tvalid"}, 80'(mv), 80'(v.ev));
    if (v.ev) begin
      chk({v.nm, ".tdata"}, 80'(md), 80'(v.ed));
      chk({v.nm, ".tkeep"}, 80'(mk_), 80'(v.ek));
      chk({v.nm, ".tlast"}, 80'(ml), 80'(v.el));
    end
    chk({v.nm, ".fill"}, 80'(f), 80'(v.ef));
    chk({v.nm, ".pkt"}, 80'(pk), 80'(v.ep));
  endtask

  task automatic p_send(input logic [63:0] d,
                        input logic [7:0] k, input bit l);
    bit acc;
    int n;
    acc = 1'b0; n = 0;
    ps.tvalid = 1'b1; ps.tdata = d; ps.tkeep = k; ps.tlast = l;
    while (!acc && n < 500) begin
      @(negedge clk); acc = ps.tready;
      @(posedge clk); #1; n++;
    end
    ps.tvalid = 1'b0;
    chk("send_accepted", 80'(acc), 80'(1));
  endtask

  task automatic p_recv(input logic [63:0] d, input bit l,
                        input string nm);
    bit          got;
    logic [64:0] cap;
    int          n;
    got = 1'b0; n = 0; cap = '0;
    pm.tready = 1'b1;
    while (!got && n < 500) begin
      @(negedge clk);
      if (pm.tvalid) begin
        got = 1'b1; cap = {pm.tlast, pm.tdata};
      end
      @(posedge clk); #1; n++;
    end
    pm.tready = 1'b0;
    chk({nm, ".got"}, 80'(got), 80'(1));
    chk(nm, 80'(cap), 80'({l, d}));
  endtask

  logic [72:0] beats[$];
  int          plen[$];

  initial begin
    areset = 1'b1;
    ps.tvalid = 0; ps.tdata = 0; ps.tkeep = 0; ps.tlast = 0;
    cs.tvalid = 0; cs.tdata = 0; cs.tkeep = 0; cs.tlast = 0;
    pm.tready = 0; cm.tready = 0;

    // test 1: packet mode, 4-beat packet, latency and order
    tbl.push_back(mk(0,1,64'h1111111111111111,8'hFF,0,1,
                     0,0,0,0, 1,0,"t1.b0"));
    tbl.push_back(mk(0,1,64'h2222222222222222,8'hFF,0,1,
                     0,0,0,0, 2,0,"t1.b1"));
    tbl.push_back(mk(0,1,64'h3333333333333333,8'hFF,0,1,
                     0,0,0,0, 3,0,"t1.b2"));
    tbl.push_back(mk(0,1,64'h4444444444444444,8'hFF,1,1,
                     0,0,0,0, 4,1,"t1.b3"));
    tbl.push_back(mk(0,0,0,0,0,1,
                     1,64'h1111111111111111,8'hFF,0, 3,1,"t1.o0"));
    tbl.push_back(mk(0,0,0,0,0,1,
                     1,64'h2222222222222222,8'hFF,0, 2,1,"t1.o1"));
    tbl.push_back(mk(0,0,0,0,0,1,
                     1,64'h3333333333333333,8'hFF,0, 1,1,"t1.o2"));
    tbl.push_back(mk(0,0,0,0,0,1,
                     1,64'h4444444444444444,8'hFF,1, 0,1,"t1.o3"));
    tbl.push_back(mk(0,0,0,0,0,1,
                     0,0,0,0, 0,0,"t1.done"));
    // test 2: cut-through single beat with partial tkeep
    tbl.push_back(mk(1,1,64'hA5A5A5A5A5A5A5A5,8'h0F,1,1,
                     0,0,0,0, 1,1,"t2.in"));
    tbl.push_back(mk(1,0,0,0,0,1,
                     1,64'hA5A5A5A5A5A5A5A5,8'h0F,1, 0,1,"t2.out"));
    tbl.push_back(mk(1,0,0,0,0,1,
                     0,0,0,0, 0,0,"t2.done"));
    // cut-through back-to-back beats stream at 1 beat/clk
    tbl.push_back(mk(1,1,64'hB1,8'h01,0,1,
                     0,0,0,0, 1,0,"t2b.in0"));
    tbl.push_back(mk(1,1,64'hB2,8'h03,1,1,
                     1,64'hB1,8'h01,0, 1,1,"t2b.in1"));
    tbl.push_back(mk(1,0,0,0,0,1,
                     1,64'hB2,8'h03,1, 0,1,"t2b.out1"));
    tbl.push_back(mk(1,0,0,0,0,1,
                     0,0,0,0, 0,0,"t2b.done"));

    // reset
    @(posedge clk); #1;
    chk("rst.p_tready_in_reset", 80'(ps.tready), 80'(0));
    chk("rst.c_tready_in_reset", 80'(cs.tready), 80'(0));
    areset = 1'b0;
    @(posedge clk); #1;
    chk("rst.p_tready", 80'(ps.tready), 80'(1));
    chk("rst.c_tready", 80'(cs.tready), 80'(1));
    chk("rst.p_tvalid", 80'(pm.tvalid), 80'(0));
    chk("rst.p_beat", 80'({pm.tlast, pm.tkeep, pm.tdata}), 80'(0));
    chk("rst.p_fill", 80'(p_fill), 80'(0));
    chk("rst.p_pkt", 80'(p_pkt), 80'(0));
    chk("rst.p_drop", 80'(p_drop), 80'(0));
    chk("rst.c_tvalid", 80'(cm.tvalid), 80'(0));
    chk("rst.c_fill", 80'(c_fill), 80'(0));
    chk("rst.c_drop", 80'(c_drop), 80'(0));

    foreach (tbl[i]) step(tbl[i]);
    ps.tvalid = 0; cs.tvalid = 0; pm.tready = 0; cm.tready = 0;

`ifndef AXI4S_PKT_FIFO_DROP_EN
    // test 3: fill cut-through FIFO with downstream stalled
    begin
      int acc;
      acc = 0;
      for (int i = 0; i < 40; i++) begin
        if (!cs.tready) break;
        cs.tvalid = 1; cs.tdata = 64'(acc);
        cs.tkeep = 8'hFF; cs.tlast = 1;
        @(posedge clk); #1;
        acc++;
      end
      cs.tvalid = 0;
      chk("t3.accepted", 80'(acc), 80'(17));
      chk("t3.fill", 80'(c_fill), 80'(16));
      chk("t3.tready_full", 80'(cs.tready), 80'(0));
      chk("t3.pkt", 80'(c_pkt), 80'(17));
      chk("t3.head", 80'({cm.tvalid, cm.tdata}), 80'({1'b1, 64'd0}));
      cm.tready = 1;
      @(posedge clk); #1;
      cm.tready = 0;
      chk("t3.tready_back", 80'(cs.tready), 80'(1));
      chk("t3.fill_pop", 80'(c_fill), 80'(15));
      chk("t3.pkt_pop", 80'(c_pkt), 80'(16));
      cm.tready = 1;
      for (int j = 1; j <= 16; j++) begin
        chk("t3.drain", 80'({cm.tvalid, cm.tdata}),
            80'({1'b1, 64'(j)}));
        @(posedge clk); #1;
      end
      cm.tready = 0;
      chk("t3.empty", 80'(cm.tvalid), 80'(0));
      chk("t3.fill_end", 80'(c_fill), 80'(0));
      chk("t3.pkt_end", 80'(c_pkt), 80'(0));
    end
`endif

    // test 4: tlast write and tlast pop on the same edge
    p_send(64'hF1, 8'hFF, 1);
    p_send(64'hF2, 8'hFF, 1);
    @(posedge clk); #1;
    chk("t4.pkt2", 80'(p_pkt), 80'(2));
    chk("t4.head", 80'({pm.tvalid, pm.tdata}), 80'({1'b1, 64'hF1}));
    ps.tvalid = 1; ps.tdata = 64'hF3; ps.tkeep = 8'hFF; ps.tlast = 1;
    pm.tready = 1;
    @(posedge clk); #1;
    ps.tvalid = 0;
    chk("t4.pkt_same", 80'(p_pkt), 80'(2));
    chk("t4.next", 80'(pm.tdata), 80'(64'hF2));
    @(posedge clk); #1;
    chk("t4.pkt1", 80'(p_pkt), 80'(1));
    chk("t4.last", 80'(pm.tdata), 80'(64'hF3));
    @(posedge clk); #1;
    pm.tready = 0;
    chk("t4.pkt0", 80'(p_pkt), 80'(0));
    chk("t4.empty", 80'(pm.tvalid), 80'(0));

`ifdef AXI4S_PKT_FIFO_DROP_EN
    // test 5: second packet overflows and is dropped
    for (int i = 0; i < 10; i++)
      p_send(64'hA00 + 64'(i), 8'hFF, i == 9);
    for (int i = 0; i < 10; i++)
      p_send(64'hB00 + 64'(i), 8'hFF, i == 9);
    chk("t5.fill_after_b", 80'(p_fill), 80'(9));
    chk("t5.drop", 80'(p_drop), 80'(1));
    chk("t5.pkt_after_b", 80'(p_pkt), 80'(1));
    for (int i = 0; i < 3; i++)
      p_send(64'hC00 + 64'(i), 8'hFF, i == 2);
    chk("t5.fill_after_c", 80'(p_fill), 80'(12));
    chk("t5.pkt_after_c", 80'(p_pkt), 80'(2));
    for (int i = 0; i < 10; i++)
      p_recv(64'hA00 + 64'(i), i == 9, "t5.a");
    for (int i = 0; i < 3; i++)
      p_recv(64'hC00 + 64'(i), i == 2, "t5.c");
    chk("t5.empty", 80'(pm.tvalid), 80'(0));
    chk("t5.pkt_end", 80'(p_pkt), 80'(0));
`endif

    // test 6: reset in the middle of a packet
    p_send(64'h51, 8'hFF, 0);
    p_send(64'h52, 8'hFF, 1);
    for (int i = 0; i < 3; i++)
      p_send(64'h60 + 64'(i), 8'hFF, 0);
    @(posedge clk); #1;
    chk("t6.fill_pre", 80'(p_fill), 80'(4));
    chk("t6.pkt_pre", 80'(p_pkt), 80'(1));
    ps.tvalid = 1; ps.tdata = 64'h63; ps.tlast = 0;
    areset = 1;
    #1;
    chk("t6.tready_rst", 80'(ps.tready), 80'(0));
    @(posedge clk); #1;
    areset = 0; ps.tvalid = 0;
    chk("t6.tvalid", 80'(pm.tvalid), 80'(0));
    chk("t6.fill", 80'(p_fill), 80'(0));
    chk("t6.pkt", 80'(p_pkt), 80'(0));
    chk("t6.data", 80'(pm.tdata), 80'(0));
    for (int i = 0; i < 6; i++)
      p_send(64'h70 + 64'(i), 8'hFF, i == 5);
    for (int i = 0; i < 6; i++)
      p_recv(64'h70 + 64'(i), i == 5, "t6.rx");
    chk("t6.empty", 80'(pm.tvalid), 80'(0));
    chk("t6.pkt_end", 80'(p_pkt), 80'(0));

    // random packets and 50% downstream ready against a scoreboard
    for (int p = 0; p < NP; p++) begin
      int len;
      len = int'($urandom_range(1, MAXL));
      plen.push_back(len);
      for (int b = 0; b < len; b++)
        beats.push_back({b == len - 1, 8'($urandom),
                         32'(p), 32'(b)});
    end
    fork
      begin
        int idx;
        idx = 0;
        for (int p = 0; p < NP; p++) begin
`ifdef AXI4S_PKT_FIFO_DROP_EN
          begin
            int w;
            w = 0;
            while (int'(p_fill) + plen[p] > 16 && w < 500) begin
              @(posedge clk); #1; w++;
            end
          end
`endif
          for (int b = 0; b < plen[p]; b++) begin
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk); #1;
            end
            p_send(beats[idx][63:0], beats[idx][71:64],
                   beats[idx][72]);
            idx++;
          end
        end
      end
      begin
        int          ridx, cyc;
        bit          hs;
        logic [72:0] cap;
        ridx = 0; cyc = 0;
        while (ridx < beats.size() && cyc < 20000) begin
          pm.tready = 1'($urandom_range(0, 1));
          @(negedge clk);
          hs  = pm.tvalid & pm.tready;
          cap = {pm.tlast, pm.tkeep, pm.tdata};
          @(posedge clk); #1;
          cyc++;
          if (hs) begin
            chk($sformatf("sb.beat%0d", ridx),
                80'(cap), 80'(beats[ridx]));
            ridx++;
          end
        end
        pm.tready = 0;
        chk("sb.count", 80'(ridx), 80'(beats.size()));
      end
    join
    @(posedge clk); #1;
    chk("sb.tvalid_end", 80'(pm.tvalid), 80'(0));
    chk("sb.fill_end", 80'(p_fill), 80'(0));
    chk("sb.pkt_end", 80'(p_pkt), 80'(0));
    chk("sb.drop_end", 80'(p_drop), 80'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
